// File: rtl/car_collision_det.sv
// Frog-versus-car collision scanner: snapshots all positions on request,
// checks one car per clock and reports the lowest overlapping car.
module car_collision_det #(
  parameter int NUM_CARS  = 10,
  parameter int c_MAX_X   = 20,
  parameter int c_CAR_LEN = 2,
  parameter int IDX_W     = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Start,
  input  logic                  i_Clear,
  input  logic [5:0]            i_Frog_X,
  input  logic [5:0]            i_Frog_Y,
  input  logic [NUM_CARS*6-1:0] i_Car_X,
  input  logic [NUM_CARS*6-1:0] i_Car_Y,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Hit,
  output logic [IDX_W-1:0]      o_Hit_Idx,
  output logic [7:0]            o_Hit_Count
);

  localparam logic [6:0]       MOD  = 7'(c_MAX_X + 1);
  localparam logic [6:0]       LEN  = 7'(c_CAR_LEN);
  localparam logic [5:0]       MAXX = 6'(c_MAX_X);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CARS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_REPORT
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [5:0]       frog_x_q;
  logic [5:0]       frog_y_q;
  logic [5:0]       car_x_q [NUM_CARS];
  logic [5:0]       car_y_q [NUM_CARS];
  logic             acc_hit_q;
  logic [IDX_W-1:0] acc_idx_q;
  logic             busy_q;
  logic             done_q;
  logic             hit_q;
  logic [IDX_W-1:0] hit_idx_q;
  logic [7:0]       cnt_q;

  logic [5:0] cur_x;
  logic [5:0] cur_y;
  logic [6:0] diff;
  logic [6:0] dx;
  logic       hit_d;

  // Distance from car tail to frog along +X, wrapped into 0..c_MAX_X
  always_comb begin
    cur_x = car_x_q[idx_q];
    cur_y = car_y_q[idx_q];
    diff  = {1'b0, frog_x_q} - {1'b0, cur_x};
    dx    = diff;
    if (frog_x_q < cur_x) dx = diff + MOD;
    hit_d = (frog_x_q <= MAXX) && (cur_x <= MAXX) &&
            (cur_y == frog_y_q) && (dx < LEN);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      frog_x_q  <= '0;
      frog_y_q  <= '0;
      for (int i = 0; i < NUM_CARS; i++) begin
        car_x_q[i] <= '0;
        car_y_q[i] <= '0;
      end
      acc_hit_q <= 1'b0;
      acc_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_Start) begin
            state_q   <= S_SCAN;
            busy_q    <= 1'b1;
            idx_q     <= '0;
            acc_hit_q <= 1'b0;
            acc_idx_q <= '0;
            frog_x_q  <= i_Frog_X;
            frog_y_q  <= i_Frog_Y;
            for (int i = 0; i < NUM_CARS; i++) begin
              car_x_q[i] <= i_Car_X[i*6 +: 6];
              car_y_q[i] <= i_Car_Y[i*6 +: 6];
            end
          end
        end
        S_SCAN: begin
          if (hit_d && !acc_hit_q) begin
            acc_hit_q <= 1'b1;
            acc_idx_q <= idx_q;
          end
          if (idx_q == LAST) begin
            state_q <= S_REPORT;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_REPORT: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          hit_q     <= acc_hit_q;
          hit_idx_q <= acc_idx_q;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (i_Clear) begin
        cnt_q <= '0;
      end else if (state_q == S_REPORT && acc_hit_q &&
                   cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Hit       = hit_q;
  assign o_Hit_Idx   = hit_idx_q;
  assign o_Hit_Count = cnt_q;

endmodule

// File: tb/tb_car_collision_det.sv
// Bench for car_collision_det: directed scenarios plus random scans
// checked against a plain-arithmetic overlap model.
module tb_car_collision_det;

  localparam int N    = 10;
  localparam int MAXX = 20;
  localparam int MOD  = MAXX + 1;
  localparam int LEN  = 2;
  localparam int IW   = 4;

  logic          i_Clk = 1'b0;
  logic          i_Reset = 1'b1;
  logic          i_Start = 1'b0;
  logic          i_Clear = 1'b0;
  logic [5:0]    i_Frog_X = '0;
  logic [5:0]    i_Frog_Y = '0;
  logic [N*6-1:0] i_Car_X = '0;
  logic [N*6-1:0] i_Car_Y = '0;
  logic          o_Busy;
  logic          o_Done;
  logic          o_Hit;
  logic [IW-1:0] o_Hit_Idx;
  logic [7:0]    o_Hit_Count;

  car_collision_det #(
    .NUM_CARS(N), .c_MAX_X(MAXX), .c_CAR_LEN(LEN), .IDX_W(IW)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start),
    .i_Clear(i_Clear), .i_Frog_X(i_Frog_X), .i_Frog_Y(i_Frog_Y),
    .i_Car_X(i_Car_X), .i_Car_Y(i_Car_Y), .o_Busy(o_Busy),
    .o_Done(o_Done), .o_Hit(o_Hit), .o_Hit_Idx(o_Hit_Idx),
    .o_Hit_Count(o_Hit_Count)
  );

  initial forever #5 i_Clk = ~i_Clk;

  int vectors = 0;
  int miscompares = 0;
  int fx, fy;
  int cx [N];
  int cy [N];
  int cnt = 0;
  int ndone;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    i_Frog_X = 6'(fx);
    i_Frog_Y = 6'(fy);
    for (int i = 0; i < N; i++) begin
      i_Car_X[i*6 +: 6] = 6'(cx[i]);
      i_Car_Y[i*6 +: 6] = 6'(cy[i]);
    end
  endtask

  task automatic model(output bit h, output int idx);
    h = 0;
    idx = 0;
    for (int i = 0; i < N; i++) begin
      if (!h && fx <= MAXX && cx[i] <= MAXX && cy[i] == fy &&
          ((fx - cx[i] + MOD) % MOD) < LEN) begin
        h = 1;
        idx = i;
      end
    end
  endtask

  task automatic park();
    for (int i = 0; i < N; i++) begin
      cx[i] = 0;
      cy[i] = 0;
    end
  endtask

  task automatic run_scan(input string tag, input bit hold,
                          input bit mutate, input bit clr);
    bit eh;
    int ei;
    drive();
    model(eh, ei);
    i_Start = 1'b1;
    @(posedge i_Clk); #1;
    if (!hold) i_Start = 1'b0;
    chk({tag, "_busy_start"}, 32'(o_Busy), 1);
    for (int c = 1; c <= N + 1; c++) begin
      if (mutate && c == 3) begin
        for (int i = 0; i < N; i++) cx[i] = $urandom_range(0, 22);
        fx = $urandom_range(0, 22);
        drive();
      end
      if (clr && c == N + 1) i_Clear = 1'b1;
      @(posedge i_Clk); #1;
      i_Clear = 1'b0;
      if (o_Done) ndone++;
      chk({tag, "_busy"}, 32'(o_Busy), 32'(c <= N));
      chk({tag, "_done"}, 32'(o_Done), 32'(c == N + 1));
    end
    if (clr) cnt = 0;
    else if (eh && cnt < 255) cnt++;
    chk({tag, "_hit"}, 32'(o_Hit), 32'(eh));
    chk({tag, "_idx"}, 32'(o_Hit_Idx), 32'(ei));
    chk({tag, "_count"}, 32'(o_Hit_Count), 32'(cnt));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(o_Busy), 0);
    chk({tag, "_done"}, 32'(o_Done), 0);
    chk({tag, "_hit"}, 32'(o_Hit), 0);
    chk({tag, "_idx"}, 32'(o_Hit_Idx), 0);
    chk({tag, "_count"}, 32'(o_Hit_Count), 0);
  endtask

  initial begin
    repeat (2) @(posedge i_Clk);
    #1;
    chk_zero("reset");
    i_Reset = 1'b0;
    @(posedge i_Clk); #1;

    park();
    fx = 5; fy = 3;
    cx[2] = 5; cy[2] = 3;
    run_scan("t1_basic", 0, 0, 0);

    park();
    fx = 0; fy = 7;
    cx[4] = 20; cy[4] = 7;
    run_scan("t2_wrap_hit", 0, 0, 0);
    fx = 1;
    run_scan("t2_wrap_miss", 0, 0, 0);
    fx = 25; cx[4] = 25;
    run_scan("t2_invalid", 0, 0, 0);

    park();
    fx = 9; fy = 4;
    cx[3] = 8; cy[3] = 4;
    cx[7] = 9; cy[7] = 4;
    run_scan("t3_multi", 0, 1, 0);

    ndone = 0;
    park();
    fx = 2; fy = 1;
    cx[6] = 2; cy[6] = 1;
    for (int s = 0; s < 3; s++) run_scan("t4_hold", 1, 0, 0);
    i_Start = 1'b0;
    chk("t4_ndone", 32'(ndone), 3);

    for (int s = 0; s < 256; s++) run_scan("t5_sat", 0, 0, 0);
    chk("t5_sat_final", 32'(o_Hit_Count), 255);
    run_scan("t5_clear", 0, 0, 1);
    run_scan("t6_pre", 0, 0, 0);

    i_Start = 1'b1;
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    repeat (3) @(posedge i_Clk);
    #1;
    i_Reset = 1'b1;
    #1;
    chk_zero("t6_rst");
    cnt = 0;
    @(posedge i_Clk); #1;
    i_Reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < N + 3; c++) begin
      @(posedge i_Clk); #1;
      if (o_Done) ndone++;
      chk("t6_idle_busy", 32'(o_Busy), 0);
    end
    chk("t6_no_done", 32'(ndone), 0);
    park();
    fx = 5; fy = 3;
    cx[2] = 5; cy[2] = 3;
    run_scan("t6_after", 0, 0, 0);

    for (int s = 0; s < 150; s++) begin
      fx = $urandom_range(0, 22);
      fy = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        cx[i] = $urandom_range(0, 22);
        cy[i] = $urandom_range(0, 2);
      end
      run_scan("rand", 0, ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
